// File: rtl/fetch_ctl.sv
// Instruction fetch / phase sequencer: walks each instruction through
// FETCH, DECODE, EXEC, optional MEM and WRITE, owning pc, instr_raw and the retired count.
module fetch_ctl #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [15:0] STUCK_LIMIT = 16'd1023
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [2:0]  state,
    output logic [31:0] instr_raw,
    output logic [31:0] pc,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        data_in,
    input  logic        data_out,
    input  logic        mem_done,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] retired,
    output logic        stuck
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WRITE  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic        req_q, req_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] retired_q, retired_d;
    logic [15:0] wait_q, wait_d, wait_inc;
    logic        stuck_q, stuck_d;
    logic        waiting;
    logic        any_mem;
    logic        unused_target_lsbs;

    // Targets are word aligned; the two low bits of branch_target are dropped.
    assign unused_target_lsbs = ^branch_target[1:0];

    assign any_mem = mem_read | mem_write | data_in | data_out;

    // Instruction memory handshake: imem_req is a registered level that stays
    // high until a cycle with imem_req=1 and imem_ack=1; that cycle transfers
    // imem_rdata. An ack seen while imem_req=0 carries no data and is ignored.
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        instr_d   = instr_q;
        pc_d      = pc_q;
        retired_d = retired_q;
        waiting   = 1'b0;

        case (state_q)
            S_FETCH: begin
                if (!req_q) begin
                    req_d   = 1'b1;
                    waiting = 1'b1;
                end else if (imem_ack) begin
                    instr_d = imem_rdata;
                    req_d   = 1'b0;
                    state_d = S_DECODE;
                end else begin
                    waiting = 1'b1;
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC:   state_d = any_mem ? S_MEM : S_WRITE;
            S_MEM: begin
                if (mem_done) state_d = S_WRITE;
                else          waiting = 1'b1;
            end
            S_WRITE: begin
                state_d   = S_FETCH;
                req_d     = 1'b1;
                pc_d      = branch_taken ? {branch_target[31:2], 2'b00} : pc_q + 32'd4;
                retired_d = retired_q + 32'd1;
            end
            default: begin
                state_d = S_FETCH;
                req_d   = 1'b1;
            end
        endcase

        // Saturating so a long hang cannot wrap the count back below the limit.
        wait_inc = (wait_q == 16'hFFFF) ? wait_q : wait_q + 16'd1;
        wait_d   = waiting ? wait_inc : 16'd0;
        stuck_d  = stuck_q | (waiting && (wait_inc >= STUCK_LIMIT));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            req_q     <= 1'b0;
            instr_q   <= 32'h0;
            pc_q      <= RESET_PC;
            retired_q <= 32'h0;
            wait_q    <= 16'h0;
            stuck_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            instr_q   <= instr_d;
            pc_q      <= pc_d;
            retired_q <= retired_d;
            wait_q    <= wait_d;
            stuck_q   <= stuck_d;
        end
    end

    assign state     = state_q;
    assign imem_req  = req_q;
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign instr_raw = instr_q;
    assign retired   = retired_q;
    assign stuck     = stuck_q;

endmodule

// File: tb/tb_fetch_ctl.sv
// Directed bench for fetch_ctl: reset, plain ALU op, load with MEM wait,
// taken branch, pc wrap, reset inside MEM and the stuck flag.
module tb_fetch_ctl;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [2:0]  state;
    logic [31:0] instr_raw;
    logic [31:0] pc;
    logic        mem_read, mem_write, data_in, data_out, mem_done;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] retired;
    logic        stuck;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    fetch_ctl #(.RESET_PC(32'h0000_0000), .STUCK_LIMIT(16'd4)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .state(state), .instr_raw(instr_raw), .pc(pc),
        .mem_read(mem_read), .mem_write(mem_write),
        .data_in(data_in), .data_out(data_out), .mem_done(mem_done),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .retired(retired), .stuck(stuck)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        imem_ack = 1'b0; imem_rdata = 32'h0;
        mem_read = 1'b0; mem_write = 1'b0; data_in = 1'b0; data_out = 1'b0;
        mem_done = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    endtask

    // from FETCH with imem_req high: ack at once, run DECODE, EXEC (no mem), WRITE
    task automatic run_alu(input logic [31:0] word, input logic take, input logic [31:0] tgt);
        imem_ack = 1'b1; imem_rdata = word;
        step();
        imem_ack = 1'b0;
        step();
        step();
        branch_taken = take; branch_target = tgt;
        step();
        branch_taken = 1'b0; branch_target = 32'h0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        // ack and mem_done during reset must be discarded
        imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF; mem_done = 1'b1;
        step();
        step();
        check("rst_state",   {29'h0, state}, 32'd0);
        check("rst_pc",      pc, 32'h0);
        check("rst_addr",    imem_addr, 32'h0);
        check("rst_req",     {31'h0, imem_req}, 32'd0);
        check("rst_instr",   instr_raw, 32'h0);
        check("rst_retired", retired, 32'h0);
        check("rst_stuck",   {31'h0, stuck}, 32'd0);

        // addi, ack on the 2nd cycle of req
        idle_inputs();
        rst_n = 1'b1;
        step();
        check("req_rise", {31'h0, imem_req}, 32'd1);
        check("st_wait",  {29'h0, state}, 32'd0);
        step();
        imem_ack = 1'b1; imem_rdata = 32'h0000_0013;
        step();
        imem_ack = 1'b0;
        check("addi_dec",   {29'h0, state}, 32'd1);
        check("addi_instr", instr_raw, 32'h0000_0013);
        check("req_drop",   {31'h0, imem_req}, 32'd0);
        step();
        check("addi_exec",  {29'h0, state}, 32'd2);
        step();
        check("addi_write", {29'h0, state}, 32'd4);
        step();
        check("addi_fetch", {29'h0, state}, 32'd0);
        check("addi_pc",    pc, 32'h4);
        check("addi_ret",   retired, 32'd1);
        check("addi_req",   {31'h0, imem_req}, 32'd1);

        // lw: stray ack in DECODE, mem_done in EXEC ignored, MEM held 3 cycles
        imem_ack = 1'b1; imem_rdata = 32'h0002_A083;
        step();
        check("lw_dec", {29'h0, state}, 32'd1);
        imem_rdata = 32'hDEAD_BEEF;
        step();
        check("stray_ack_instr", instr_raw, 32'h0002_A083);
        check("lw_exec", {29'h0, state}, 32'd2);
        imem_ack = 1'b0;
        mem_read = 1'b1; mem_done = 1'b1;
        step();
        mem_read = 1'b0; mem_done = 1'b0;
        check("lw_mem1", {29'h0, state}, 32'd3);
        step();
        check("lw_mem2", {29'h0, state}, 32'd3);
        step();
        check("lw_mem3", {29'h0, state}, 32'd3);
        check("lw_pc_hold", pc, 32'h4);
        mem_done = 1'b1;
        step();
        mem_done = 1'b0;
        check("lw_write", {29'h0, state}, 32'd4);
        step();
        check("lw_fetch", {29'h0, state}, 32'd0);
        check("lw_pc",    pc, 32'h8);
        check("lw_addr",  imem_addr, 32'h8);
        check("lw_ret",   retired, 32'd2);

        // taken branch to an unaligned target
        run_alu(32'h0000_0063, 1'b1, 32'h0000_0103);
        check("br_pc",   pc, 32'h0000_0100);
        check("br_addr", imem_addr, 32'h0000_0100);
        check("br_ret",  retired, 32'd3);

        // pc wrap: branch to the last word, then fall through to 0
        run_alu(32'h0000_0063, 1'b1, 32'hFFFF_FFFF);
        check("top_pc", pc, 32'hFFFF_FFFC);
        run_alu(32'h0000_0013, 1'b0, 32'h0);
        check("wrap_pc",  pc, 32'h0);
        check("wrap_ret", retired, 32'd5);
        check("no_stuck", {31'h0, stuck}, 32'd0);

        // reset asserted in MEM on the same edge as mem_done
        imem_ack = 1'b1; imem_rdata = 32'h0000_0023;
        step();
        imem_ack = 1'b0;
        step();
        data_out = 1'b1;
        step();
        data_out = 1'b0;
        check("sw_mem", {29'h0, state}, 32'd3);
        rst_n = 1'b0; mem_done = 1'b1;
        step();
        mem_done = 1'b0;
        check("memrst_state", {29'h0, state}, 32'd0);
        check("memrst_pc",    pc, 32'h0);
        check("memrst_ret",   retired, 32'd0);
        check("memrst_instr", instr_raw, 32'h0);
        check("memrst_req",   {31'h0, imem_req}, 32'd0);

        // no ack ever: stuck raises once the wait reaches 4 and stays after ack
        rst_n = 1'b1;
        step();
        step();
        step();
        check("stuck_early", {31'h0, stuck}, 32'd0);
        step();
        step();
        step();
        check("stuck_set",   {31'h0, stuck}, 32'd1);
        check("stuck_state", {29'h0, state}, 32'd0);
        check("stuck_req",   {31'h0, imem_req}, 32'd1);
        imem_ack = 1'b1; imem_rdata = 32'h0000_0013;
        step();
        imem_ack = 1'b0;
        check("stuck_dec",    {29'h0, state}, 32'd1);
        check("stuck_sticky", {31'h0, stuck}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_ctl.md
FETCH_CTL -- requirements
Module: fetch_ctl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter STUCK_LIMIT, default 16'd1023, FETCH/MEM wait cycles before stuck flag raised.
REQ-003 clk  in  1  single clock, all logic on posedge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 imem_req  out  1  instruction read request, held until acknowledged.
REQ-006 imem_addr  out  32  word address of requested instruction (= pc).
REQ-007 imem_ack  in  1  instruction read done, imem_rdata valid same cycle.
REQ-008 imem_rdata  in  32  instruction word.
REQ-009 state  out  3  phase code to decode/exec/mem: FETCH=0, DECODE=1, EXEC=2, MEM=3, WRITE=4.
REQ-010 instr_raw  out  32  latched instruction, stable from DECODE through WRITE.
REQ-011 pc  out  32  address of instruction in flight.
REQ-012 mem_read, mem_write, data_in, data_out  in  1 each  decoder flags, sampled in EXEC.
REQ-013 mem_done  in  1  data memory / IO access complete.
REQ-014 branch_taken  in  1  exec result: redirect PC, sampled in WRITE.
REQ-015 branch_target  in  32  redirect address, sampled in WRITE.
REQ-016 retired  out  32  count of instructions completing WRITE.
REQ-017 stuck  out  1  sticky flag: wait exceeded STUCK_LIMIT.

Function
REQ-018 FSM SHALL have exactly five states, encoded as REQ-009; codes 5-7 SHALL return to FETCH next cycle.
REQ-019 FETCH: imem_req=1, imem_addr=pc; on cycle with imem_ack=1 SHALL latch imem_rdata into instr_raw, drop imem_req, enter DECODE next cycle.
REQ-020 imem_req SHALL be registered; rises on the edge that enters FETCH, and on the first edge after rst_n goes high.
REQ-021 imem_ack while imem_req=0 SHALL be ignored (no instr_raw update, no state change).
REQ-022 DECODE SHALL last exactly 1 cycle, then EXEC.
REQ-023 EXEC SHALL last exactly 1 cycle; next state MEM if any of mem_read, mem_write, data_in, data_out is 1, else WRITE.
REQ-024 MEM SHALL hold until mem_done=1, then WRITE next cycle; mem_done outside MEM ignored.
REQ-025 WRITE SHALL last exactly 1 cycle, then FETCH; on that edge pc <= branch_taken ? {branch_target[31:2],2'b00} : pc+4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0).
REQ-026 retired SHALL increment by 1 on each WRITE exit, wrapping 32'hFFFF_FFFF -> 0.
REQ-027 Minimum instruction latency: FETCH(1 with ack same cycle as req)+DECODE+EXEC+WRITE = 4 cycles; with MEM and immediate mem_done = 5.
REQ-028 A wait counter SHALL count consecutive cycles in FETCH without ack or in MEM without mem_done; clears on state exit; when it reaches STUCK_LIMIT, stuck SHALL set and remain set until reset; FSM keeps waiting.
REQ-029 instr_raw and pc SHALL not change outside the edges specified in REQ-019 and REQ-025.

Reset
REQ-030 rst_n=0 at any edge, in any state, SHALL set: state=FETCH, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, instr_raw=0, retired=0, stuck=0, wait counter=0.
REQ-031 Any imem_ack or mem_done during or pending across reset SHALL be discarded; fetch restarts at RESET_PC.

Verification
REQ-032 Reset release, imem_ack on 2nd cycle of req, rdata=32'h0000_0013 (addi) -> sequence 0,1,2,4,0; pc=4, retired=1.
REQ-033 lw (mem_read=1 in EXEC), mem_done delayed 3 cycles -> MEM held 3 cycles then WRITE; pc=+4, total 7 cycles.
REQ-034 branch_taken=1, branch_target=32'h0000_0103 in WRITE -> pc=32'h0000_0100, next imem_addr=32'h0000_0100.
REQ-035 pc=32'hFFFF_FFFC, no branch -> pc=0 after WRITE; retired preloaded 32'hFFFF_FFFF wraps to 0.
REQ-036 rst_n=0 during MEM with mem_done=1 same edge -> state=FETCH, pc=RESET_PC, retired unchanged-to-0, no WRITE occurs.
REQ-037 STUCK_LIMIT=4, imem_ack never asserted -> stuck=1 after 4 waiting cycles, state stays 0; later ack -> DECODE, stuck stays 1.
